// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and helpers for the pipelined add/sub unit.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        ADDC = 2'd2,
        SUBB = 2'd3
    } addsub_op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic neg;
    } addsub_flags_t;

    // Subtracting ops feed the inverted B operand into the adder.
    function automatic logic op_inverts_b(addsub_op_e op);
        return (op == SUB) || (op == SUBB);
    endfunction

    // Carry into bit 0; for SUBB a set cin is a borrow, hence inverted.
    function automatic logic op_carry_in(addsub_op_e op, logic cin);
        case (op)
            ADD:     return 1'b0;
            SUB:     return 1'b1;
            ADDC:    return cin;
            default: return ~cin;
        endcase
    endfunction

    // Only single-word ops may saturate; multi-word chains must wrap.
    function automatic logic op_saturates(addsub_op_e op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: one SEG_W-bit registered slice of the add/sub carry chain.
module addsub_seg #(
    parameter int SEG_W = 8
) (
    input  logic             soc_clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);

    logic [SEG_W:0]   total_d;
    logic [SEG_W-1:0] sum_q;
    logic             cout_q;

    assign total_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};

    // Capture the slice sum and its carry-out whenever the pipe advances.
    always_ff @(posedge soc_clk or negedge reset_n) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (!reset_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= total_d[SEG_W-1:0];
            cout_q <= total_d[SEG_W];
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit add/subtract with valid/ready handshake.
// The carry chain is cut into STAGES slices, one addsub_seg per stage.
// Define ADDSUB_SAT_EN to saturate ADD/SUB results on signed overflow.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             soc_clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int              SEG_W    = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}});

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a multiple of STAGES");
    end

    addsub_op_e op;
    logic       advance;

    // Per-stage registers. a_q[k] carries the finished sum slices below
    // slice k and the untouched A slices above it; b_q[k] carries B'.
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];

    // Stage inputs; a_d[STAGES] is the fully assembled raw sum.
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES+1];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             cin_d   [STAGES];

    logic [SEG_W-1:0] seg_sum  [STAGES];
    logic             seg_cout [STAGES];

`ifdef ADDSUB_SAT_EN
    logic plain_q [STAGES];
    logic plain_d [STAGES];
`endif

    assign op       = addsub_op_e'(in_op);
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign valid_d[0] = in_valid;
    assign a_d[0]     = in_a;
    assign b_d[0]     = op_inverts_b(op) ? ~in_b : in_b;
    assign cin_d[0]   = op_carry_in(op, in_cin);
`ifdef ADDSUB_SAT_EN
    assign plain_d[0] = op_saturates(op);
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LSB = k * SEG_W;

        if (k > 0) begin : g_link
            assign valid_d[k] = valid_q[k-1];
            assign b_d[k]     = b_q[k-1];
            assign cin_d[k]   = seg_cout[k-1];
`ifdef ADDSUB_SAT_EN
            assign plain_d[k] = plain_q[k-1];
`endif
        end

        // Replace slice k of the carried word with this stage's sum.
        assign a_d[k+1] = (a_q[k] & ~(SEG_MASK << LSB)) |
                          (WIDTH'(seg_sum[k]) << LSB);

        addsub_seg #(.SEG_W(SEG_W)) u_seg (
            .soc_clk (soc_clk),
            .reset_n (reset_n),
            .en_i    (advance),
            .a_i     (a_d[k][LSB +: SEG_W]),
            .b_i     (b_d[k][LSB +: SEG_W]),
            .cin_i   (cin_d[k]),
            .sum_o   (seg_sum[k]),
            .cout_o  (seg_cout[k])
        );
    end

    // Shift the whole pipe one stage on advance; hold everything on stall.
    always_ff @(posedge soc_clk or negedge reset_n) begin
        // NOTE: data registers are reset as well because the last stage
        // drives the outputs, which must read as zero out of reset.
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
`ifdef ADDSUB_SAT_EN
                plain_q[k] <= 1'b0;
`endif
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
`ifdef ADDSUB_SAT_EN
                plain_q[k] <= plain_d[k];
`endif
            end
        end
    end

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] result;
    logic             a_msb;
    logic             b_msb;
    addsub_flags_t    flags;
    logic             unused_b_low;

    assign raw_sum      = a_d[STAGES];
    assign a_msb        = a_q[STAGES-1][WIDTH-1];
    assign b_msb        = b_q[STAGES-1][WIDTH-1];
    assign unused_b_low = ^b_q[STAGES-1][WIDTH-2:0];

    // Final-stage flags and optional saturation of the assembled sum.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch.
        result         = raw_sum;
        flags.carry    = seg_cout[STAGES-1];
        flags.overflow = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
        if (plain_q[STAGES-1] && flags.overflow) begin
            result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags.zero     = (result == '0);
        flags.neg      = result[WIDTH-1];
    end

    assign out_valid    = valid_q[STAGES-1];
    assign out_result   = result;
    assign out_carry    = flags.carry;
    assign out_overflow = flags.overflow;
    assign out_zero     = flags.zero;
    assign out_neg      = flags.neg;

endmodule
